spram_arb: RTL
==============

# spram_arb

Two-requester arbiter and sequencer for the 136x64 single-port RAM in the rsp_s2_prep datapath. Two independent masters (m0, m1) issue read/write requests through valid/ready handshakes. The block grants at most one access per cycle using round-robin, drives the RAM port, and returns read data to the owning master after the RAM's fixed read delay. Out-of-range addresses are trapped and answered with an error response; such accesses never reach the RAM.

## Interface
Parameters:
- DATA_DEPTH, 136, RAM word count
- DATA_WIDTH, 64, word width
- RD_DELAY, 1, RAM read latency in clka edges (≥1); must match the attached RAM
- ADDR_WIDTH, $clog2(DATA_DEPTH), address width
- RTSEL_VAL, 2'b00, constant driven on ram_rtsel
- WTSEL_VAL, 2'b00, constant driven on ram_wtsel

Ports:
- clka  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- mN_req_valid  in  1  request valid (N = 0, 1)
- mN_req_ready  out  1  request accepted this cycle
- mN_req_we  in  1  1 = write, 0 = read
- mN_req_addr  in  ADDR_WIDTH  word address
- mN_req_wdata  in  DATA_WIDTH  write data
- mN_req_bwe  in  DATA_WIDTH  per-bit write enable
- mN_resp_valid  out  1  one-cycle response pulse
- mN_resp_rdata  out  DATA_WIDTH  read data (0 on error or write)
- mN_resp_err  out  1  address ≥ DATA_DEPTH
- ram_en, ram_wen  out  1  RAM enable / write enable
- ram_addr  out  ADDR_WIDTH; ram_din, ram_bwe  out  DATA_WIDTH
- ram_dout  in  DATA_WIDTH  RAM read data
- ram_rtsel, ram_wtsel  out  2  timing-select constants

## Operation
- Arbitration (combinational, each cycle): only one valid → grant it. Both valid → grant the master `prio` points to. A cycle with no valid request grants nobody.
- `prio` register: reset → m0. After any grant, `prio` moves to the master not granted. Under continuous contention the grants therefore alternate m0, m1, m0, …
- mN_req_ready = grant to mN. Ready does not depend on the other master's ready. A master holds its valid and payload until it sees ready.
- In-range grant: ram_en = 1. ram_wen, ram_addr, ram_din and ram_bwe are taken from the granted master in the same cycle.
- Out-of-range grant (addr ≥ DATA_DEPTH): ram_en = 0. The request is still accepted, and its response is error-tagged.
- Idle cycle: ram_en = 0, ram_wen = 0. Address and data outputs are 0.
- Response tag pipeline has RD_DELAY+1 stages. Each stage holds {valid, owner, is_read, err}. The tag enters on the grant cycle.
- Response payload:
  - In-range read → resp_rdata = registered ram_dout, resp_err = 0.
  - In-range write → resp_valid pulses, resp_rdata = 0, err = 0. This is the write acknowledge.
  - Error → resp_rdata = 0, resp_err = 1.
- Response carries no backpressure. Every master must accept responses every cycle.
- Responses to each master arrive in grant order. The pipeline sustains one request per cycle.

## Timing
- Request accepted at cycle T (rising edge ending T). The RAM samples en/addr at that edge.
- ram_dout is valid during cycle T+RD_DELAY. It is registered at the end of that cycle.
- mN_resp_valid is high for exactly cycle T+RD_DELAY+1. Latency is RD_DELAY+1 cycles for reads, writes and errors alike.
- Read immediately after a write to the same address (grants at T and T+1) → the read returns the new data.
- Reset values, all asserted asynchronously:
  - all resp_valid = 0, resp_rdata = 0, resp_err = 0
  - tag pipeline cleared, prio = m0
  - ram_en = 0, ram_wen = 0
  - req_ready follows the combinational grant rule and is forced to 0 while rst = 1
- Reset mid-operation: in-flight responses are discarded, with no late pulses after reset release. RAM contents are untouched.

## Test plan
- Single read, RD_DELAY=1: preload addr 5 = 64'hDEAD_BEEF_0000_0001. m0 reads 5 at T → m0_resp_valid at T+2 with that data, err 0. m1_resp_valid stays 0.
- Write then read: m1 writes 64'h1234 to addr 10 with full bwe at T, then reads 10 at T+1 → write ack at T+2, read data 64'h1234 at T+3.
- Contention: both masters hold valid reads for 6 cycles → grants alternate m0, m1, m0, m1, m0, m1. Each master receives 3 responses, in order.
- Partial write: bwe = 64'h0000_0000_FFFF_FFFF, wdata all ones over a word of zeros → read returns 64'h0000_0000_FFFF_FFFF.
- Out-of-range: m0 reads addr 136 → ram_en stays 0, and m0_resp_valid at T+2 carries err = 1, rdata = 0.
- Reset: assert rst one cycle after a grant → no resp_valid pulse for that request, prio = m0, and the first contended grant after release goes to m0. Repeat with RD_DELAY = 3, expecting latency 4.

Source files
------------

// File: rtl/spram_arb.sv
// Round-robin arbiter and sequencer that lets two masters share a single-port RAM.
// Out-of-range accesses are answered with an error and never reach the RAM.
module spram_arb #(
  parameter int          DATA_DEPTH = 136,
  parameter int          DATA_WIDTH = 64,
  parameter int          RD_DELAY   = 1,
  parameter int          ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter logic [1:0]  RTSEL_VAL  = 2'b00,
  parameter logic [1:0]  WTSEL_VAL  = 2'b00
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  input  logic [DATA_WIDTH-1:0] m0_req_bwe,
  output logic                  m0_resp_valid,
  output logic [DATA_WIDTH-1:0] m0_resp_rdata,
  output logic                  m0_resp_err,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  input  logic [DATA_WIDTH-1:0] m1_req_bwe,
  output logic                  m1_resp_valid,
  output logic [DATA_WIDTH-1:0] m1_resp_rdata,
  output logic                  m1_resp_err,
  output logic                  ram_en,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [DATA_WIDTH-1:0] ram_bwe,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [1:0]            ram_rtsel,
  output logic [1:0]            ram_wtsel
);

  localparam int                LAST    = RD_DELAY - 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DATA_DEPTH[ADDR_WIDTH:0];

  logic                  prio;  // 0 = m0 wins the next contended cycle
  logic                  gnt0, gnt1, gnt_any, in_range;
  logic                  g_we;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata, g_bwe;

  logic [RD_DELAY-1:0]   tag_vld_p, tag_own_p, tag_rd_p, tag_err_p;
  logic                  rsp0, rsp1, rsp_data;

  // Grant and RAM drive: combinational, same cycle as the handshake
  always_comb begin
    gnt0     = !rst && m0_req_valid && (!m1_req_valid || !prio);
    gnt1     = !rst && m1_req_valid && (!m0_req_valid ||  prio);
    gnt_any  = gnt0 || gnt1;
    g_we     = gnt1 ? m1_req_we    : m0_req_we;
    g_addr   = gnt1 ? m1_req_addr  : m0_req_addr;
    g_wdata  = gnt1 ? m1_req_wdata : m0_req_wdata;
    g_bwe    = gnt1 ? m1_req_bwe   : m0_req_bwe;
    in_range = ({1'b0, g_addr} < DEPTH_L);

    ram_en   = gnt_any && in_range;
    ram_wen  = ram_en && g_we;
    ram_addr = ram_en ? g_addr  : '0;
    ram_din  = ram_en ? g_wdata : '0;
    ram_bwe  = ram_en ? g_bwe   : '0;
  end

  assign m0_req_ready = gnt0;
  assign m1_req_ready = gnt1;
  assign ram_rtsel    = RTSEL_VAL;
  assign ram_wtsel    = WTSEL_VAL;

  // The last tag stage lines up with ram_dout being valid
  assign rsp0     = tag_vld_p[LAST] && !tag_own_p[LAST];
  assign rsp1     = tag_vld_p[LAST] &&  tag_own_p[LAST];
  assign rsp_data = tag_rd_p[LAST] && !tag_err_p[LAST];

  // Tag stages _p0.._p(RD_DELAY-1), then the registered response stage
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      prio          <= 1'b0;
      tag_vld_p     <= '0;
      tag_own_p     <= '0;
      tag_rd_p      <= '0;
      tag_err_p     <= '0;
      m0_resp_valid <= 1'b0;
      m0_resp_rdata <= '0;
      m0_resp_err   <= 1'b0;
      m1_resp_valid <= 1'b0;
      m1_resp_rdata <= '0;
      m1_resp_err   <= 1'b0;
    end else begin
      if (gnt0)      prio <= 1'b1;
      else if (gnt1) prio <= 1'b0;

      tag_vld_p[0] <= gnt_any;
      tag_own_p[0] <= gnt1;
      tag_rd_p[0]  <= !g_we;
      tag_err_p[0] <= gnt_any && !in_range;
      for (int i = 1; i < RD_DELAY; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_own_p[i] <= tag_own_p[i-1];
        tag_rd_p[i]  <= tag_rd_p[i-1];
        tag_err_p[i] <= tag_err_p[i-1];
      end

      m0_resp_valid <= rsp0;
      m0_resp_err   <= rsp0 && tag_err_p[LAST];
      m0_resp_rdata <= (rsp0 && rsp_data) ? ram_dout : '0;
      m1_resp_valid <= rsp1;
      m1_resp_err   <= rsp1 && tag_err_p[LAST];
      m1_resp_rdata <= (rsp1 && rsp_data) ? ram_dout : '0;
    end
  end

endmodule
